lmem_arbiter: RTL and testbench

//  Shares the single layer-memory port (cwr/crd/caddr/cdata/csel) between two

---
 rtl/lmem_pkg.sv | 18 +
 rtl/lmem_rr_pick.sv | 22 ++
 rtl/lmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_lmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmem_pkg.sv
// Shared constants for the layer-memory arbiter: owner encoding, layer selects
// and default bus widths.
package lmem_pkg;

    localparam int LMEM_AW = 12;
    localparam int LMEM_DW = 20;
    localparam int LMEM_SW = 3;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE = 2'd0;
    localparam owner_t OWN_R0   = 2'd1;
    localparam owner_t OWN_R1   = 2'd2;

    localparam logic [LMEM_SW-1:0] CSEL_L0 = 3'b001;
    localparam logic [LMEM_SW-1:0] CSEL_L1 = 3'b011;

endpackage

// File: rtl/lmem_rr_pick.sv
// Combinational round-robin chooser: the requester after 'last' is tried
// first, then the other one; nobody requesting yields OWN_NONE.
module lmem_rr_pick
    import lmem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output owner_t     pick
);

    always_comb begin
        pick = OWN_NONE;
        if (last == OWN_R0) begin
            if (req[1])      pick = OWN_R1;
            else if (req[0]) pick = OWN_R0;
        end else begin
            if (req[0])      pick = OWN_R0;
            else if (req[1]) pick = OWN_R1;
        end
    end

endmodule

// File: rtl/lmem_arbiter.sv
// Two-requester layer-memory arbiter (R0 = conv engine, R1 = max-pool engine).
// Optional LMEM_ARB_STATS_EN adds saturating grant/stall counters.
module lmem_arbiter
    import lmem_pkg::*;
#(
    parameter int AW = LMEM_AW,
    parameter int DW = LMEM_DW,
    parameter int SW = LMEM_SW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          we0,
    input  logic          we1,
    input  logic [SW-1:0] sel0,
    input  logic [SW-1:0] sel1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          cwr,
    output logic          crd,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    input  logic [DW-1:0] cdata_rd,
    output logic [SW-1:0] csel,
    output logic          busy
`ifdef LMEM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_gnt0,
    output logic [15:0]   stat_gnt1,
    output logic [15:0]   stat_stall0,
    output logic [15:0]   stat_stall1
`endif
);

    // Handshake: an access is transferred in every cycle where reqN & gntN.
    // gntN depends only on the owner register and reqN. A granted read returns
    // rvalidN the following cycle with rdata; rvalidN has no back-pressure.

    owner_t owner, owner_nx, last, pick;
    logic          gnt_any;
    logic          g_we;
    logic [SW-1:0] g_sel;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    lmem_rr_pick u_pick (
        .req  ({req1, req0}),
        .last (last),
        .pick (pick)
    );

    // A locked owner that still requests keeps the port; otherwise round-robin.
    always_comb begin
        owner_nx = pick;
        if (owner == OWN_R0 && req0 && lock0)      owner_nx = OWN_R0;
        else if (owner == OWN_R1 && req1 && lock1) owner_nx = OWN_R1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner <= OWN_NONE;
            last  <= OWN_R1;
        end else begin
            owner <= owner_nx;
            if (owner_nx != OWN_NONE) last <= owner_nx;
        end
    end

    assign gnt0    = (owner == OWN_R0) & req0;
    assign gnt1    = (owner == OWN_R1) & req1;
    assign gnt_any = gnt0 | gnt1;

    always_comb begin
        g_we    = we0;
        g_sel   = sel0;
        g_addr  = addr0;
        g_wdata = wdata0;
        if (gnt1) begin
            g_we    = we1;
            g_sel   = sel1;
            g_addr  = addr1;
            g_wdata = wdata1;
        end
    end

    assign cwr      = gnt_any & g_we;
    assign crd      = gnt_any & ~g_we;
    assign csel     = gnt_any ? g_sel : '0;
    assign caddr_wr = gnt_any ? g_addr : addr_q;
    assign caddr_rd = gnt_any ? g_addr : addr_q;
    assign cdata_wr = gnt_any ? g_wdata : wdata_q;

    // Address/data hold their last granted value while the port is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (gnt_any) begin
            addr_q  <= g_addr;
            wdata_q <= g_wdata;
        end
    end

    // cdata_rd is captured at the end of the crd cycle; the tag is the issuer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata   <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (crd) rdata <= cdata_rd;
        end
    end

    assign busy = (owner != OWN_NONE) | rvalid0 | rvalid1;

`ifdef LMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_gnt0   <= '0;
            stat_gnt1   <= '0;
            stat_stall0 <= '0;
            stat_stall1 <= '0;
        end else begin
            if (gnt0 && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
            if (gnt1 && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
            if (req0 && !gnt0 && stat_stall0 != 16'hFFFF) stat_stall0 <= stat_stall0 + 16'd1;
            if (req1 && !gnt1 && stat_stall1 != 16'hFFFF) stat_stall1 <= stat_stall1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lmem_arbiter.sv
// Testbench for lmem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the arbitration rules.
module tb_lmem_arbiter;

    typedef struct packed {
        logic        req;
        logic        lock;
        logic        we;
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [19:0] wdata;
    } rq_t;

    logic        clk, reset;
    logic        req0, req1, lock0, lock1, we0, we1;
    logic [2:0]  sel0, sel1;
    logic [11:0] addr0, addr1;
    logic [19:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, cwr, crd, busy;
    logic [19:0] rdata, cdata_wr, cdata_rd;
    logic [11:0] caddr_wr, caddr_rd;
    logic [2:0]  csel;
`ifdef LMEM_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_stall0, stat_stall1;
`endif

    int checks = 0;
    int errors = 0;

    lmem_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
        .we0(we0), .we1(we1), .sel0(sel0), .sel1(sel1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .cwr(cwr), .crd(crd),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr),
        .cdata_rd(cdata_rd), .csel(csel), .busy(busy)
`ifdef LMEM_ARB_STATS_EN
        , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
        .stat_stall0(stat_stall0), .stat_stall1(stat_stall1)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] iv(input int i);
        return 20'((i * 37 + 11) ^ 20'h5A5A5);
    endfunction

    // layer memory: asynchronous read, synchronous write
    logic [19:0] mem  [0:4095];
    logic [19:0] mmem [0:4095];
    initial for (int i = 0; i < 4096; i++) begin
        mem[i]  = iv(i);
        mmem[i] = iv(i);
    end
    assign cdata_rd = mem[caddr_rd];
    always @(posedge clk) if (cwr) mem[caddr_wr] <= cdata_wr;

    // behavioural model: owner 0 = none, 1 = R0, 2 = R1
    int          m_owner, m_last;
    bit          m_rv0, m_rv1;
    logic [19:0] m_rdata, m_data_h;
    logic [11:0] m_addr_h;
    int          m_sg0, m_sg1, m_ss0, m_ss1;

    always @(posedge clk or posedge reset) begin
        int gi, nxt, cand;
        bit rq [2];
        if (reset) begin
            m_owner = 0; m_last = 2; m_rv0 = 0; m_rv1 = 0;
            m_rdata = '0; m_addr_h = '0; m_data_h = '0;
            m_sg0 = 0; m_sg1 = 0; m_ss0 = 0; m_ss1 = 0;
        end else begin
            rq[0] = req0; rq[1] = req1;
            gi = -1;
            if (m_owner == 1 && req0) gi = 0;
            if (m_owner == 2 && req1) gi = 1;
            if (gi == 0 && m_sg0 < 65535) m_sg0++;
            if (gi == 1 && m_sg1 < 65535) m_sg1++;
            if (req0 && gi != 0 && m_ss0 < 65535) m_ss0++;
            if (req1 && gi != 1 && m_ss1 < 65535) m_ss1++;
            m_rv0 = 0; m_rv1 = 0;
            if (gi >= 0) begin
                m_addr_h = gi ? addr1 : addr0;
                m_data_h = gi ? wdata1 : wdata0;
                if (gi ? we1 : we0) mmem[m_addr_h] = m_data_h;
                else begin
                    m_rdata = mmem[m_addr_h];
                    if (gi == 0) m_rv0 = 1; else m_rv1 = 1;
                end
            end
            if (m_owner == 1 && req0 && lock0) nxt = 1;
            else if (m_owner == 2 && req1 && lock1) nxt = 2;
            else begin
                nxt = 0;
                for (int k = 1; k <= 2; k++) begin
                    cand = (m_last + k - 1) % 2 + 1;
                    if (nxt == 0 && rq[cand-1]) nxt = cand;
                end
            end
            if (nxt != 0) m_last = nxt;
            m_owner = nxt;
        end
    end

    // scoreboard
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        bit g0, g1, ga, w;
        logic [2:0]  s;
        logic [11:0] a;
        logic [19:0] d;
        g0 = (m_owner == 1) && req0;
        g1 = (m_owner == 2) && req1;
        ga = g0 || g1;
        w  = g1 ? we1 : we0;
        s  = g1 ? sel1 : sel0;
        a  = g1 ? addr1 : addr0;
        d  = g1 ? wdata1 : wdata0;
        chk("gnt0", gnt0, g0);
        chk("gnt1", gnt1, g1);
        chk("cwr", cwr, ga && w);
        chk("crd", crd, ga && !w);
        chk("csel", csel, ga ? s : 3'd0);
        chk("caddr_wr", caddr_wr, ga ? a : m_addr_h);
        chk("caddr_rd", caddr_rd, ga ? a : m_addr_h);
        chk("cdata_wr", cdata_wr, ga ? d : m_data_h);
        chk("rvalid0", rvalid0, m_rv0);
        chk("rvalid1", rvalid1, m_rv1);
        chk("rdata", rdata, m_rdata);
        chk("busy", busy, (m_owner != 0) || m_rv0 || m_rv1);
`ifdef LMEM_ARB_STATS_EN
        chk("stat_gnt0", stat_gnt0, m_sg0);
        chk("stat_gnt1", stat_gnt1, m_sg1);
        chk("stat_stall0", stat_stall0, m_ss0);
        chk("stat_stall1", stat_stall1, m_ss1);
`endif
    endtask

    // driver tasks
    function automatic rq_t mk(input bit r, l, w, input logic [2:0] s,
                               input logic [11:0] a, input logic [19:0] d);
        rq_t p;
        p.req = r; p.lock = l; p.we = w; p.sel = s; p.addr = a; p.wdata = d;
        return p;
    endfunction

    task automatic apply(input rq_t p0, input rq_t p1);
        req0 = p0.req; lock0 = p0.lock; we0 = p0.we; sel0 = p0.sel;
        addr0 = p0.addr; wdata0 = p0.wdata;
        req1 = p1.req; lock1 = p1.lock; we1 = p1.we; sel1 = p1.sel;
        addr1 = p1.addr; wdata1 = p1.wdata;
    endtask

    task automatic cyc(input rq_t p0, input rq_t p1);
        @(negedge clk);
        apply(p0, p1);
        #1 compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply('0, '0);
        reset = 1'b1;
        #1 compare_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic rq_t rnd_rq();
        return mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? 3'b011 : 3'b001,
                  12'($urandom_range(0, 31)), 20'($urandom));
    endfunction

    localparam rq_t IDLE = '0;

    initial begin
        rq_t p0, p1;
        reset = 1'b1;
        apply('0, '0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_crd", crd, 0);
        chk("rst_caddr_rd", caddr_rd, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        compare_all();
        reset = 1'b0;

        // single read by R0
        p0 = mk(1, 0, 0, 3'b001, 12'h005, 20'h0);
        cyc(p0, IDLE);
        chk("t1_rise_gnt0", gnt0, 0);
        cyc(p0, IDLE);
        chk("t1_gnt0", gnt0, 1);
        chk("t1_crd", crd, 1);
        chk("t1_caddr_rd", caddr_rd, 12'h005);
        chk("t1_csel", csel, 3'b001);
        cyc(IDLE, IDLE);
        chk("t1_rvalid0", rvalid0, 1);
        chk("t1_rdata", rdata, iv(5));
        cyc(IDLE, IDLE);
        cyc(IDLE, IDLE);

        // alternating grants
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(mk(1, 0, 0, 3'b001, 12'(20 + i), 20'h0),
                mk(1, 0, 1, 3'b011, 12'(40 + i), 20'(1000 + i)));
            chk("t2_gnt0", gnt0, (i == 1 || i == 3));
            chk("t2_gnt1", gnt1, (i == 2 || i == 4));
        end
        cyc(IDLE, IDLE);

        // locked write burst by R1 while R0 waits
        do_reset();
        cyc(IDLE, mk(1, 1, 1, 3'b011, 12'd0, 20'd100));
        chk("t3_rise_gnt1", gnt1, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(mk(1, 0, 0, 3'b001, 12'd7, 20'h0),
                mk(1, i < 3, 1, 3'b011, 12'(i), 20'(100 + i)));
            chk("t3_gnt1", gnt1, 1);
            chk("t3_gnt0", gnt0, 0);
            chk("t3_caddr_wr", caddr_wr, i);
        end
        cyc(mk(1, 0, 0, 3'b001, 12'd7, 20'h0), IDLE);
        chk("t3_after_gnt0", gnt0, 1);
        cyc(IDLE, IDLE);

        // two reads by R0, then a write by R1
        do_reset();
        cyc(mk(1, 1, 0, 3'b001, 12'd10, 20'h0), IDLE);
        cyc(mk(1, 1, 0, 3'b001, 12'd10, 20'h0), IDLE);
        chk("t4_gnt0_a", gnt0, 1);
        cyc(mk(1, 0, 0, 3'b001, 12'd11, 20'h0), mk(1, 0, 1, 3'b011, 12'd40, 20'h777));
        chk("t4_gnt0_b", gnt0, 1);
        chk("t4_rvalid0_a", rvalid0, 1);
        chk("t4_rdata_a", rdata, iv(10));
        cyc(IDLE, mk(1, 0, 1, 3'b011, 12'd40, 20'h777));
        chk("t4_gnt1", gnt1, 1);
        chk("t4_rvalid0_b", rvalid0, 1);
        chk("t4_rdata_b", rdata, iv(11));
        chk("t4_rvalid1", rvalid1, 0);
        cyc(IDLE, IDLE);
        chk("t4_rvalid0_end", rvalid0, 0);
        chk("t4_rvalid1_end", rvalid1, 0);

        // reset in the middle of a locked read burst
        do_reset();
        p0 = mk(1, 1, 0, 3'b001, 12'd12, 20'h0);
        p1 = mk(1, 0, 1, 3'b011, 12'd50, 20'h123);
        cyc(p0, IDLE);
        cyc(p0, IDLE);
        cyc(mk(1, 1, 0, 3'b001, 12'd13, 20'h0), IDLE);
        chk("t5_pre_gnt0", gnt0, 1);
        chk("t5_pre_rvalid0", rvalid0, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_gnt0", gnt0, 0);
        chk("t5_crd", crd, 0);
        chk("t5_csel", csel, 0);
        chk("t5_caddr_rd", caddr_rd, 0);
        chk("t5_rvalid0", rvalid0, 0);
        chk("t5_rdata", rdata, 0);
        chk("t5_busy", busy, 0);
        compare_all();
        @(negedge clk);
        apply(p0, p1);
        #1 compare_all();
        @(negedge clk);
        reset = 1'b0;
        #1 compare_all();
        chk("t5_rel_gnt0", gnt0, 0);
        cyc(mk(1, 0, 0, 3'b001, 12'd14, 20'h0), p1);
        chk("t5_prio_gnt0", gnt0, 1);
        chk("t5_prio_gnt1", gnt1, 0);
        cyc(IDLE, IDLE);

`ifdef LMEM_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 11; i++)
            cyc(mk(1, 0, 0, 3'b001, 12'd20, 20'h0), mk(1, 0, 1, 3'b011, 12'd60, 20'h5));
        cyc(IDLE, IDLE);
        chk("t6_stat_gnt0", stat_gnt0, 5);
        chk("t6_stat_gnt1", stat_gnt1, 5);
        chk("t6_stat_stall0", stat_stall0, 6);
        chk("t6_stat_stall1", stat_stall1, 6);
`endif

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            cyc(rnd_rq(), rnd_rq());
        end
        cyc(IDLE, IDLE);
        cyc(IDLE, IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
